// File: rtl/sknobs_hw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sknobs_hw_pkg                                                              |
// | Shared types and default widths for the key/value responder table.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sknobs_hw_pkg;

   localparam int unsigned KT_NUM_ENTRIES = 16;
   localparam int unsigned KT_KEY_W       = 32;
   localparam int unsigned KT_VAL_W       = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      RESP   = 2'd2,
      WRITE  = 2'd3
   } kt_state_e;

   typedef enum logic {
      OP_GET = 1'b0,
      OP_SET = 1'b1
   } kt_op_e;

   typedef struct packed {
      logic [KT_KEY_W-1:0] key;
      logic [KT_VAL_W-1:0] value;
   } kt_entry_t;

endpackage
`default_nettype wire

// File: rtl/sknobs_kt_storage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sknobs_kt_storage                                                          |
// | Entry array: one write port, one combinational read port, no reset.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sknobs_kt_storage
   import sknobs_hw_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = KT_NUM_ENTRIES,
   parameter int unsigned KEY_W       = KT_KEY_W,
   parameter int unsigned VAL_W       = KT_VAL_W,
   parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [VAL_W-1:0] wr_value,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [KEY_W-1:0] rd_key,
   output logic [VAL_W-1:0] rd_value
);

   logic [KEY_W-1:0] key_q   [NUM_ENTRIES];
   logic [KEY_W-1:0] key_d   [NUM_ENTRIES];
   logic [VAL_W-1:0] value_q [NUM_ENTRIES];
   logic [VAL_W-1:0] value_d [NUM_ENTRIES];

   always_comb begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         key_d[i]   = key_q[i];
         value_d[i] = value_q[i];
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            key_d[i]   = wr_key;
            value_d[i] = wr_value;
         end
      end
   end

   // Payloads are deliberately unreset; the occupancy count guards every read.
   always_ff @(posedge clk) begin
      key_q   <= key_d;
      value_q <= value_d;
   end

   assign rd_key   = key_q[rd_idx];
   assign rd_value = value_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/sknobs_knob_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sknobs_knob_table                                                          |
// | Runtime-parameter get/set responder: linear-scan key table, default-on-miss|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sknobs_knob_table
   import sknobs_hw_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = KT_NUM_ENTRIES,
   parameter int unsigned KEY_W       = KT_KEY_W,
   parameter int unsigned VAL_W       = KT_VAL_W,
   parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             set_valid,
   output logic             set_ready,
   input  logic [KEY_W-1:0] set_key,
   input  logic [VAL_W-1:0] set_value,
   output logic             set_err,
   input  logic             get_valid,
   output logic             get_ready,
   input  logic [KEY_W-1:0] get_key,
   input  logic [VAL_W-1:0] get_default,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [VAL_W-1:0] rsp_value,
   output logic             rsp_exists,
   output logic [IDX_W:0]   count,
   output logic             full
);

   localparam int unsigned CNT_W = IDX_W + 1;

   kt_state_e        state_q, state_d;
   kt_op_e           op_q, op_d;
   logic [KEY_W-1:0] req_key_q, req_key_d;
   logic [VAL_W-1:0] req_val_q, req_val_d;
   logic [VAL_W-1:0] req_dflt_q, req_dflt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [VAL_W-1:0] rsp_value_q, rsp_value_d;
   logic             rsp_exists_q, rsp_exists_d;

   logic             full_w, empty_w, last_w, match_w, wr_en_w;
   logic [IDX_W-1:0] wr_idx_w;
   logic [KEY_W-1:0] rd_key_w;
   logic [VAL_W-1:0] rd_value_w;

   assign full_w   = (count_q == CNT_W'(NUM_ENTRIES));
   assign empty_w  = (count_q == '0);
   assign last_w   = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
   assign match_w  = (rd_key_w == req_key_q);
   // A hit keeps idx_q parked on the matching entry; a miss appends at count.
   assign wr_idx_w = hit_q ? idx_q : count_q[IDX_W-1:0];

   sknobs_kt_storage #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .KEY_W       (KEY_W),
      .VAL_W       (VAL_W),
      .IDX_W       (IDX_W)
   ) u_storage (
      .clk      (clk),
      .wr_en    (wr_en_w),
      .wr_idx   (wr_idx_w),
      .wr_key   (req_key_q),
      .wr_value (req_val_q),
      .rd_idx   (idx_q),
      .rd_key   (rd_key_w),
      .rd_value (rd_value_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= OP_GET;
         req_key_q    <= '0;
         req_val_q    <= '0;
         req_dflt_q   <= '0;
         idx_q        <= '0;
         hit_q        <= 1'b0;
         count_q      <= '0;
         rsp_value_q  <= '0;
         rsp_exists_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         req_key_q    <= req_key_d;
         req_val_q    <= req_val_d;
         req_dflt_q   <= req_dflt_d;
         idx_q        <= idx_d;
         hit_q        <= hit_d;
         count_q      <= count_d;
         rsp_value_q  <= rsp_value_d;
         rsp_exists_q <= rsp_exists_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      req_key_d    = req_key_q;
      req_val_d    = req_val_q;
      req_dflt_d   = req_dflt_q;
      idx_d        = idx_q;
      hit_d        = hit_q;
      count_d      = count_q;
      rsp_value_d  = rsp_value_q;
      rsp_exists_d = rsp_exists_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (set_valid) begin
               op_d      = OP_SET;
               req_key_d = set_key;
               req_val_d = set_value;
               idx_d     = '0;
               hit_d     = 1'b0;
               state_d   = empty_w ? WRITE : SEARCH;
            end else if (get_valid) begin
               op_d       = OP_GET;
               req_key_d  = get_key;
               req_dflt_d = get_default;
               idx_d      = '0;
               hit_d      = 1'b0;
               if (empty_w) begin
                  rsp_value_d  = get_default;
                  rsp_exists_d = 1'b0;
                  state_d      = RESP;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (match_w) begin
               hit_d = 1'b1;
               if (op_q == OP_GET) begin
                  rsp_value_d  = rd_value_w;
                  rsp_exists_d = 1'b1;
                  state_d      = RESP;
               end else begin
                  state_d = WRITE;
               end
            end else if (last_w) begin
               if (op_q == OP_GET) begin
                  rsp_value_d  = req_dflt_q;
                  rsp_exists_d = 1'b0;
                  state_d      = RESP;
               end else begin
                  state_d = WRITE;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            state_d = IDLE;
            if (!hit_q && !full_w) begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      set_ready = (state_q == IDLE) && !clear;
      get_ready = (state_q == IDLE) && !clear && !set_valid;
      rsp_valid = (state_q == RESP);
      set_err   = (state_q == WRITE) && !hit_q && full_w;
      wr_en_w   = (state_q == WRITE) && (hit_q || !full_w);
   end

   assign rsp_value  = rsp_value_q;
   assign rsp_exists = rsp_exists_q;
   assign count      = count_q;
   assign full       = full_w;

endmodule
`default_nettype wire

// File: tb/tb_sknobs_knob_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sknobs_knob_table                                                       |
// | Directed + random stimulus against a cycle-timed key/value table model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sknobs_knob_table;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        set_valid = 1'b0;
   logic        get_valid = 1'b0;
   logic        rsp_ready = 1'b0;
   logic [31:0] set_key = '0;
   logic [31:0] get_key = '0;
   logic [63:0] set_value = '0;
   logic [63:0] get_default = '0;
   logic        set_ready, set_err, get_ready, rsp_valid, rsp_exists, full;
   logic [63:0] rsp_value;
   logic [4:0]  count;

   int total = 0;
   int bad   = 0;

   sknobs_knob_table dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .set_valid   (set_valid),
      .set_ready   (set_ready),
      .set_key     (set_key),
      .set_value   (set_value),
      .set_err     (set_err),
      .get_valid   (get_valid),
      .get_ready   (get_ready),
      .get_key     (get_key),
      .get_default (get_default),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_value   (rsp_value),
      .rsp_exists  (rsp_exists),
      .count       (count),
      .full        (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ordered key/value list plus the cycle at which the
   // pending operation resolves (response start or write cycle).
   logic [31:0] m_keys[$];
   logic [63:0] m_vals[$];
   int          m_mode = 0;   // 0 idle, 1 get outstanding, 2 set outstanding
   int          m_hit  = -1;
   int          m_ev   = 0;
   int          cyc    = 0;
   bit          m_live = 1'b0;
   logic [31:0] m_sk;
   logic [63:0] m_sv, m_rv;
   logic        m_re, m_err;

   function automatic int find_key(input logic [31:0] k);
      foreach (m_keys[i]) if (m_keys[i] == k) return i;
      return -1;
   endfunction

   function automatic int resolve_cycle(input int t, input int hit, input int n);
      return (hit >= 0) ? t + 2 + hit : t + 1 + n;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_mode = 0;
            m_keys.delete();
            m_vals.delete();
            m_live = 1'b1;
         end else if (m_live) begin
            case (m_mode)
               0: begin
                  if (clear) begin
                     m_keys.delete();
                     m_vals.delete();
                  end else if (set_valid) begin
                     m_hit  = find_key(set_key);
                     m_sk   = set_key;
                     m_sv   = set_value;
                     m_ev   = resolve_cycle(cyc, m_hit, m_keys.size());
                     m_err  = (m_hit < 0) && (m_keys.size() == N);
                     m_mode = 2;
                  end else if (get_valid) begin
                     m_hit  = find_key(get_key);
                     m_ev   = resolve_cycle(cyc, m_hit, m_keys.size());
                     m_re   = (m_hit >= 0);
                     m_rv   = (m_hit >= 0) ? m_vals[m_hit] : get_default;
                     m_mode = 1;
                  end
               end
               1: if (cyc >= m_ev && rsp_ready) m_mode = 0;
               2: if (cyc == m_ev) begin
                  if (m_hit >= 0) m_vals[m_hit] = m_sv;
                  else if (m_keys.size() < N) begin
                     m_keys.push_back(m_sk);
                     m_vals.push_back(m_sv);
                  end
                  m_mode = 0;
               end
               default: m_mode = 0;
            endcase
         end
         cyc++;
      end
   end

   initial begin
      bit idle, rsp;
      forever begin
         @(negedge clk);
         if (m_live) begin
            idle = (m_mode == 0);
            rsp  = (m_mode == 1) && (cyc >= m_ev);
            check("set_ready", 64'(set_ready), 64'(idle && !clear));
            check("get_ready", 64'(get_ready), 64'(idle && !clear && !set_valid));
            check("rsp_valid", 64'(rsp_valid), 64'(rsp));
            if (rsp) begin
               check("rsp_value", rsp_value, m_rv);
               check("rsp_exists", 64'(rsp_exists), 64'(m_re));
            end
            check("set_err", 64'(set_err), 64'((m_mode == 2) && (cyc == m_ev) && m_err));
            check("count", 64'(count), 64'(m_keys.size()));
            check("full", 64'(full), 64'(m_keys.size() == N));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input bit is_set, input string name);
      int n = 0;
      forever begin
         @(negedge clk);
         if ((is_set ? set_ready : get_ready) || n >= 64) break;
         step();
         n++;
      end
      check(name, 64'(n < 64), 64'(1));
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      forever begin
         @(negedge clk);
         if (rsp_valid || lat >= 64) break;
         step();
         lat++;
      end
   endtask

   task automatic run_get(input logic [31:0] k, input logic [63:0] d,
                          output int lat, output logic [63:0] v, output logic e);
      get_valid = 1'b1; get_key = k; get_default = d; rsp_ready = 1'b1;
      wait_ready(1'b0, "get_accept_timeout");
      step();
      get_valid = 1'b0;
      wait_rsp(lat);
      v = rsp_value;
      e = rsp_exists;
      step();
   endtask

   task automatic run_set(input logic [31:0] k, input logic [63:0] v, output int errs);
      int n = 0;
      set_valid = 1'b1; set_key = k; set_value = v;
      wait_ready(1'b1, "set_accept_timeout");
      step();
      set_valid = 1'b0;
      errs = 0;
      forever begin
         @(negedge clk);
         if (set_err) errs++;
         if (set_ready || n >= 64) break;
         step();
         n++;
      end
      step();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      @(negedge clk);
      check("clear_count", 64'(count), 64'(0));
      step();
   endtask

   function automatic logic [31:0] rand_key();
      logic [31:0] k;
      k = 32'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 1) k = k | 32'h8000_0000;
      return k;
   endfunction

   initial begin
      int lat, errs;
      logic [63:0] v, v0;
      logic e, e0;

      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("reset_count", 64'(count), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_rsp_value", rsp_value, 64'(0));
      check("reset_full", 64'(full), 64'(0));
      step();

      // empty table miss
      run_get(32'h11, 64'h5, lat, v, e);
      check("empty_get_lat", 64'(lat), 64'(1));
      check("empty_get_exists", 64'(e), 64'(0));
      check("empty_get_value", v, 64'h5);

      // hit on second entry
      run_set(32'hA, 64'd100, errs);
      run_set(32'hB, 64'd200, errs);
      check("two_sets_count", 64'(count), 64'(2));
      run_get(32'hB, 64'h0, lat, v, e);
      check("hitB_lat", 64'(lat), 64'(3));
      check("hitB_exists", 64'(e), 64'(1));
      check("hitB_value", v, 64'd200);

      // clear, then overwrite
      do_clear();
      run_get(32'hB, 64'h77, lat, v, e);
      check("after_clear_exists", 64'(e), 64'(0));
      check("after_clear_value", v, 64'h77);
      run_set(32'hA, 64'd100, errs);
      run_set(32'hA, 64'd7, errs);
      check("overwrite_count", 64'(count), 64'(1));
      run_get(32'hA, 64'h0, lat, v, e);
      check("overwrite_value", v, 64'd7);
      check("overwrite_lat", 64'(lat), 64'(2));

      // fill to capacity, then overflow
      do_clear();
      for (int i = 0; i < N; i++) run_set(32'(i), 64'(1000 + i), errs);
      run_set(32'hFF, 64'd1, errs);
      check("overflow_err_pulses", 64'(errs), 64'(1));
      check("overflow_count", 64'(count), 64'(16));
      check("overflow_full", 64'(full), 64'(1));
      run_get(32'hFF, 64'h1234, lat, v, e);
      check("overflow_get_lat", 64'(lat), 64'(17));
      check("overflow_get_exists", 64'(e), 64'(0));
      check("overflow_get_value", v, 64'h1234);
      run_get(32'h0, 64'h0, lat, v, e);
      check("key0_value", v, 64'd1000);
      run_get(32'hF, 64'h0, lat, v, e);
      check("last_entry_lat", 64'(lat), 64'(17));
      check("last_entry_value", v, 64'd1015);
      run_set(32'h3, 64'd42, errs);
      check("full_overwrite_err", 64'(errs), 64'(0));
      run_get(32'h3, 64'h0, lat, v, e);
      check("full_overwrite_value", v, 64'd42);

      // same-cycle set and get: set wins, get sees the new value
      do_clear();
      set_valid = 1'b1; set_key = 32'hC; set_value = 64'd9;
      get_valid = 1'b1; get_key = 32'hC; get_default = 64'h0; rsp_ready = 1'b1;
      @(negedge clk);
      check("same_cycle_get_ready", 64'(get_ready), 64'(0));
      check("same_cycle_set_ready", 64'(set_ready), 64'(1));
      step();
      set_valid = 1'b0;
      run_get(32'hC, 64'h0, lat, v, e);
      check("same_cycle_get_exists", 64'(e), 64'(1));
      check("same_cycle_get_value", v, 64'd9);

      // response held under backpressure
      get_valid = 1'b1; get_key = 32'hC; get_default = 64'h5; rsp_ready = 1'b0;
      wait_ready(1'b0, "hold_accept_timeout");
      step();
      get_valid = 1'b0;
      wait_rsp(lat);
      v0 = rsp_value;
      e0 = rsp_exists;
      check("hold_first_value", v0, 64'd9);
      repeat (5) begin
         step();
         @(negedge clk);
         check("hold_valid", 64'(rsp_valid), 64'(1));
         check("hold_value", rsp_value, v0);
         check("hold_exists", 64'(rsp_exists), 64'(e0));
      end
      step();
      rsp_ready = 1'b1;
      step();
      @(negedge clk);
      check("hold_release", 64'(rsp_valid), 64'(0));
      step();

      // reset during a scan
      for (int i = 0; i < 6; i++) run_set(32'h200 + 32'(i), 64'(i), errs);
      get_valid = 1'b1; get_key = 32'h999; get_default = 64'h1;
      wait_ready(1'b0, "rst_accept_timeout");
      step();
      get_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_mid_count", 64'(count), 64'(0));
      step();
      run_get(32'hC, 64'h3, lat, v, e);
      check("rst_prior_key_miss", 64'(e), 64'(0));

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         set_valid   = ($urandom_range(0, 99) < 35);
         set_key     = rand_key();
         set_value   = {$urandom(), $urandom()};
         get_valid   = ($urandom_range(0, 99) < 40);
         get_key     = rand_key();
         get_default = {$urandom(), $urandom()};
         rsp_ready   = ($urandom_range(0, 99) < 60);
         clear       = ($urandom_range(0, 99) < 1);
         rst         = ($urandom_range(0, 999) < 2);
         step();
      end
      set_valid = 1'b0; get_valid = 1'b0; clear = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
